// File: rtl/reg_gpr_wrarb.sv
// reg_gpr_wrarb: arbitrates the single GPR file write port between the
// in-order pipeline writeback (requester A) and a long-latency unit
// (requester B). B results are buffered in a small FIFO so that B can
// complete independently of the pipeline. A per-GPR pending scoreboard
// tells ID which registers still await a long-latency result.
//
// Optional feature: define PIPPO_WRARB_BYPASS_EN to let a B beat write
// the file in its acceptance cycle when nothing else competes for the
// port and the FIFO is empty (zero-latency bypass). Without it, every
// accepted B beat is enqueued first.
//
// rf_we, rf_addr, rf_data, a_stall and b_ready are combinational decodes
// of registered FIFO state. They are not registered because the bypass
// path must reach the file in the same cycle the beat is accepted, and
// a_stall must freeze the pipeline in the cycle the conflict exists.

module reg_gpr_wrarb #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int FD = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_freeze,
  input  logic              flushpipe,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DW-1:0]     a_data,
  input  logic              b_valid,
  input  logic [AW-1:0]     b_addr,
  input  logic [DW-1:0]     b_data,
  output logic              b_ready,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  output logic              rf_we,
  output logic [AW-1:0]     rf_addr,
  output logic [DW-1:0]     rf_data,
  output logic              a_stall,
  output logic [(1<<AW)-1:0] pend_vec
);

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int NR = 1 << AW;

  // Write-port source chosen for the current cycle.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_A    = 2'd1,
    SRC_HEAD = 2'd2,
    SRC_BYP  = 2'd3
  } src_e;

  // One-hot decode of a GPR number into a scoreboard mask.
  function automatic logic [NR-1:0] addr_onehot(input logic [AW-1:0] addr);
    logic [NR-1:0] mask;
    mask = {{(NR-1){1'b0}}, 1'b1} << addr;
    return mask;
  endfunction

  // FIFO storage and pointers.
  logic [AW-1:0] fifo_addr_r [FD];
  logic [DW-1:0] fifo_data_r [FD];
  logic [PW:0]   wr_ptr_r;
  logic [PW:0]   rd_ptr_r;
  logic [NR-1:0] pend_r;

  // Combinational decode.
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          a_live_s;
  logic          b_fire_s;
  logic          bypass_ok_s;
  src_e          src_s;
  logic          push_s;
  logic          pop_s;
  logic [AW-1:0] head_addr_s;
  logic [DW-1:0] head_data_s;
  logic [NR-1:0] pend_set_s;
  logic [NR-1:0] pend_clr_s;
  logic [NR-1:0] pend_next_s;

  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PW] != rd_ptr_r[PW]) &&
                        (wr_ptr_r[PW-1:0] == rd_ptr_r[PW-1:0]);
  assign head_addr_s  = fifo_addr_r[rd_ptr_r[PW-1:0]];
  assign head_data_s  = fifo_data_r[rd_ptr_r[PW-1:0]];

  // A only counts as a live request when the pipeline is not flushing it.
  assign a_live_s = a_we & ~flushpipe;

  // B handshake: ready depends only on FIFO occupancy (and reset), never on
  // b_valid. A full FIFO keeps ready low even in a cycle that dequeues, so a
  // same-cycle push/pop only ever happens on a non-full FIFO.
  assign b_ready  = ~fifo_full_s & ~rst;
  assign b_fire_s = b_valid & b_ready;

`ifdef PIPPO_WRARB_BYPASS_EN
  assign bypass_ok_s = b_fire_s & fifo_empty_s & ~a_live_s & ~wb_freeze;
`else
  assign bypass_ok_s = 1'b0;
`endif

  // Pipeline must hold A while the full FIFO drains through the port.
  assign a_stall = a_we & fifo_full_s & ~wb_freeze & ~rst;

  // Choose the write source: freeze blocks everything, a full FIFO beats A
  // so B can always make progress, otherwise A beats the queue.
  always_comb begin
    src_s = SRC_NONE;
    if (rst) begin
      src_s = SRC_NONE;
    end else if (wb_freeze) begin
      src_s = SRC_NONE;
    end else if (fifo_full_s) begin
      src_s = SRC_HEAD;
    end else if (a_live_s) begin
      src_s = SRC_A;
    end else if (!fifo_empty_s) begin
      src_s = SRC_HEAD;
    end else if (bypass_ok_s) begin
      src_s = SRC_BYP;
    end else begin
      src_s = SRC_NONE;
    end
  end

  // Drive the file write port from the selected source.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = head_addr_s;
    rf_data = head_data_s;
    case (src_s)
      SRC_A: begin
        rf_we   = 1'b1;
        rf_addr = a_addr;
        rf_data = a_data;
      end
      SRC_HEAD: begin
        rf_we   = 1'b1;
        rf_addr = head_addr_s;
        rf_data = head_data_s;
      end
      SRC_BYP: begin
        rf_we   = 1'b1;
        rf_addr = b_addr;
        rf_data = b_data;
      end
      default: begin
        rf_we   = 1'b0;
        rf_addr = head_addr_s;
        rf_data = head_data_s;
      end
    endcase
  end

  // FIFO control: the head leaves only when it actually wrote the file, and
  // a bypassed beat never occupies a slot.
  assign pop_s  = (src_s == SRC_HEAD);
  assign push_s = b_fire_s & (src_s != SRC_BYP);

  // Scoreboard update: B retirement clears its bit, an issue sets its bit,
  // and set wins when both hit the same register in one cycle.
  always_comb begin
    pend_set_s = '0;
    pend_clr_s = '0;
    if (iss_valid) begin
      pend_set_s = addr_onehot(iss_addr);
    end else begin
      pend_set_s = '0;
    end
    case (src_s)
      SRC_HEAD: pend_clr_s = addr_onehot(head_addr_s);
      SRC_BYP:  pend_clr_s = addr_onehot(b_addr);
      default:  pend_clr_s = '0;
    endcase
    pend_next_s = (pend_r & ~pend_clr_s) | pend_set_s;
  end

  // FIFO payload storage; contents are meaningless outside the pointer
  // window, so only the pointers need reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_addr_r[wr_ptr_r[PW-1:0]] <= b_addr;
      fifo_data_r[wr_ptr_r[PW-1:0]] <= b_data;
    end
  end

  // FIFO pointers; reset discards any in-flight B results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{PW{1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{PW{1'b0}}, 1'b1};
      end
    end
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= '0;
    end else begin
      pend_r <= pend_next_s;
    end
  end

  assign pend_vec = pend_r;

endmodule

// File: tb/tb_reg_gpr_wrarb.sv
// Directed bench for reg_gpr_wrarb with a write-order scoreboard: the
// stimulus pushes each expected GPR write, the monitor pops one per rf_we.
module tb_reg_gpr_wrarb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_freeze, flushpipe;
  logic          a_we;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          a_stall;
  logic [31:0]   pend_vec;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  reg_gpr_wrarb #(.DW(DW), .AW(AW), .FD(FD)) dut (
    .clk(clk), .rst(rst), .wb_freeze(wb_freeze), .flushpipe(flushpipe),
    .a_we(a_we), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .a_stall(a_stall), .pend_vec(pend_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every file write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write", rf_addr, rf_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {59'd0, rf_addr}, {59'd0, mon_e.addr});
        chk("wr_data", {32'd0, rf_data}, {32'd0, mon_e.data});
      end
    end
  end

  initial begin
    rst = 1'b1; wb_freeze = 1'b0; flushpipe = 1'b0;
    a_we = 1'b1; a_addr = 5'd2; a_data = 32'h22;
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    iss_valid = 1'b0; iss_addr = 5'd0;

    // Reset: traffic present but nothing may write or stall.
    @(negedge clk);
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_a_stall", {63'd0, a_stall}, 64'd0);
    cyc();
    rst = 1'b0; a_we = 1'b0; b_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_b_ready", {63'd0, b_ready}, 64'd1);
    chk("post_rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("post_rst_pend", {32'd0, pend_vec}, 64'd0);
    cyc();
    @(negedge clk);
    chk("idle_rf_we", {63'd0, rf_we}, 64'd0);

    // Issue to r7, then B returns r7.
    cyc();
    iss_valid = 1'b1; iss_addr = 5'd7;
    cyc();
    iss_valid = 1'b0;
    b_valid = 1'b1; b_addr = 5'd7; b_data = 32'hDEADBEEF;
    expect_wr(5'd7, 32'hDEADBEEF);
    @(negedge clk);
    chk("pend7_set", {63'd0, pend_vec[7]}, 64'd1);
`ifndef PIPPO_WRARB_BYPASS_EN
    chk("b_lat_acc_cycle", {63'd0, rf_we}, 64'd0);
`endif
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
`ifndef PIPPO_WRARB_BYPASS_EN
    chk("b_lat_next_cycle", {63'd0, rf_we}, 64'd1);
    chk("pend7_before_edge", {63'd0, pend_vec[7]}, 64'd1);
`else
    chk("b_byp_next_cycle", {63'd0, rf_we}, 64'd0);
`endif
    cyc();
    @(negedge clk);
    chk("pend7_clear", {32'd0, pend_vec}, 64'd0);
    chk("after_b_rf_we", {63'd0, rf_we}, 64'd0);

    // A writes every cycle while two B beats fill the FIFO.
    cyc();
    a_we = 1'b1; a_addr = 5'd1; a_data = 32'hA1;
    b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hB0;
    expect_wr(5'd1, 32'hA1);
    cyc();
    a_addr = 5'd2; a_data = 32'hA2;
    b_addr = 5'd11; b_data = 32'hB1;
    expect_wr(5'd2, 32'hA2);
    cyc();
    a_addr = 5'd3; a_data = 32'h11; b_valid = 1'b0;
    expect_wr(5'd10, 32'hB0);
    @(negedge clk);
    chk("full_a_stall", {63'd0, a_stall}, 64'd1);
    chk("full_b_ready", {63'd0, b_ready}, 64'd0);
    cyc();
    // One slot free again: A (held) takes priority over the remaining head.
    expect_wr(5'd3, 32'h11);
    @(negedge clk);
    chk("unfull_a_stall", {63'd0, a_stall}, 64'd0);
    chk("unfull_b_ready", {63'd0, b_ready}, 64'd1);
    cyc();
    a_we = 1'b0;
    expect_wr(5'd11, 32'hB1);
    cyc();
    @(negedge clk);
    chk("drained_rf_we", {63'd0, rf_we}, 64'd0);

    // Flushed A write: the queued B entry uses the port instead.
    cyc();
    a_we = 1'b1; a_addr = 5'd4; a_data = 32'hA4;
    b_valid = 1'b1; b_addr = 5'd12; b_data = 32'hC0;
    expect_wr(5'd4, 32'hA4);
    cyc();
    b_valid = 1'b0;
    a_addr = 5'd5; a_data = 32'h55; flushpipe = 1'b1;
    expect_wr(5'd12, 32'hC0);
    @(negedge clk);
    chk("flush_rf_we", {63'd0, rf_we}, 64'd1);
    cyc();
    a_we = 1'b0; flushpipe = 1'b0;
    @(negedge clk);
    chk("post_flush_rf_we", {63'd0, rf_we}, 64'd0);

    // Freeze for 3 cycles with one entry queued.
    cyc();
    wb_freeze = 1'b1;
    b_valid = 1'b1; b_addr = 5'd13; b_data = 32'hD0;
    @(negedge clk);
    chk("freeze_rf_we_0", {63'd0, rf_we}, 64'd0);
    cyc();
    b_valid = 1'b0;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("freeze_rf_we_%0d", i), {63'd0, rf_we}, 64'd0);
      cyc();
    end
    wb_freeze = 1'b0;
    expect_wr(5'd13, 32'hD0);
    @(negedge clk);
    chk("unfreeze_rf_we", {63'd0, rf_we}, 64'd1);
    cyc();

    // Issue to r5 in the same cycle r5 retires: set must win.
    iss_valid = 1'b1; iss_addr = 5'd5;
    cyc();
    iss_valid = 1'b0;
    a_we = 1'b1; a_addr = 5'd6; a_data = 32'h66;
    b_valid = 1'b1; b_addr = 5'd5; b_data = 32'hE0;
    expect_wr(5'd6, 32'h66);
    cyc();
    a_we = 1'b0; b_valid = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd5;
    expect_wr(5'd5, 32'hE0);
    cyc();
    iss_valid = 1'b0;
    @(negedge clk);
    chk("pend5_set_wins", {32'd0, pend_vec}, 64'h20);

    // Reset with a B entry in flight: it must be discarded.
    cyc();
    a_we = 1'b1; a_addr = 5'd1; a_data = 32'h77;
    b_valid = 1'b1; b_addr = 5'd14; b_data = 32'hF0;
    expect_wr(5'd1, 32'h77);
    cyc();
    a_we = 1'b0; b_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_pend", {32'd0, pend_vec}, 64'd0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_discard", {63'd0, rf_we}, 64'd0);
    chk("postrst_b_ready", {63'd0, b_ready}, 64'd1);
    cyc();
    cyc();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
